// File: rtl/tile_draw_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// tile_draw_arbiter_pkg : shared widths, FSM encoding and colours for the VGA
//                         pixel-port arbiter.
// Rev 1.0
// ============================================================================
package tile_draw_arbiter_pkg;

  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int COLOR_W = 9;
  localparam int CNT_W   = 16;

  localparam logic [COLOR_W-1:0] WHITE = 9'h1ff;
  localparam logic [COLOR_W-1:0] GREEN = 9'h0a0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Pixel counter sticks at all-ones rather than wrapping on very long bursts.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_draw_arbiter_if.sv
`default_nettype none
// ============================================================================
// tile_draw_arbiter_if : draw-engine request bus plus the registered VGA
//                        pixel stream and burst status.
// Rev 1.0
// ============================================================================
interface tile_draw_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import tile_draw_arbiter_pkg::*;

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ*X_W-1:0]     req_x;
  logic [NUM_REQ*Y_W-1:0]     req_y;
  logic [NUM_REQ*COLOR_W-1:0] req_color;

  logic [NUM_REQ-1:0]         grant;
  logic [X_W-1:0]             VGA_X;
  logic [Y_W-1:0]             VGA_Y;
  logic [COLOR_W-1:0]         VGA_COLOR;
  logic                       plot;
  logic                       burst_done;
  logic [2:0]                 done_id;
  logic [CNT_W-1:0]           burst_pixels;
  logic                       timeout_err;

  modport master (
    output req, req_valid, req_last, req_x, req_y, req_color,
    input  grant, VGA_X, VGA_Y, VGA_COLOR, plot, burst_done, done_id,
           burst_pixels, timeout_err
  );

  modport slave (
    input  req, req_valid, req_last, req_x, req_y, req_color,
    output grant, VGA_X, VGA_Y, VGA_COLOR, plot, burst_done, done_id,
           burst_pixels, timeout_err
  );

endinterface
`default_nettype wire

// File: rtl/draw_rr_pick.sv
`default_nettype none
// ============================================================================
// draw_rr_pick : rotate-priority encoder, first requester at or after rr_ptr.
// Rev 1.0
// ============================================================================
module draw_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  logic [IDX_W:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, rr_ptr_i} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (req_i[cand[IDX_W-1:0]]) begin
        idx_o   = cand[IDX_W-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tile_draw_arbiter.sv
`default_nettype none
// ============================================================================
// tile_draw_arbiter : burst-locked round-robin owner of the VGA write port.
// Rev 1.0
// ============================================================================
module tile_draw_arbiter
  import tile_draw_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 2048
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  tile_draw_arbiter_if.slave bus
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int IDLE_W = $clog2(TIMEOUT);

  state_e             state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]   pix_cnt_q;
  logic [IDLE_W-1:0]  idle_cnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [X_W-1:0]     vga_x_q;
  logic [Y_W-1:0]     vga_y_q;
  logic [COLOR_W-1:0] vga_color_q;
  logic               plot_q;
  logic               burst_done_q;
  logic [2:0]         done_id_q;
  logic [CNT_W-1:0]   burst_pixels_q;
  logic               timeout_err_q;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               own_req;
  logic               own_valid;
  logic               own_last;
  logic               idle_expired;
  logic               end_normal;
  logic               end_abort;
  logic [CNT_W-1:0]   pix_cnt_d;
  logic [IDX_W-1:0]   rr_ptr_d;

  draw_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  assign own_req      = bus.req[owner_q];
  assign own_valid    = bus.req_valid[owner_q];
  assign own_last     = bus.req_last[owner_q];
  assign idle_expired = (idle_cnt_q == IDLE_W'(TIMEOUT - 1));
  assign end_normal   = own_valid && own_last;
  // A pixel arriving with the req drop is still counted before the abort.
  assign end_abort    = !end_normal && (!own_req || (!own_valid && idle_expired));
  assign pix_cnt_d    = sat_inc(pix_cnt_q, own_valid);
  assign rr_ptr_d     = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q        <= IDLE;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      pix_cnt_q      <= '0;
      idle_cnt_q     <= '0;
      grant_q        <= '0;
      vga_x_q        <= '0;
      vga_y_q        <= '0;
      vga_color_q    <= '0;
      plot_q         <= 1'b0;
      burst_done_q   <= 1'b0;
      done_id_q      <= '0;
      burst_pixels_q <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      plot_q        <= 1'b0;
      burst_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            owner_q    <= pick_idx;
            grant_q    <= NUM_REQ'(1) << pick_idx;
            pix_cnt_q  <= '0;
            idle_cnt_q <= '0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (own_valid) begin
            vga_x_q     <= bus.req_x[owner_q*X_W +: X_W];
            vga_y_q     <= bus.req_y[owner_q*Y_W +: Y_W];
            vga_color_q <= bus.req_color[owner_q*COLOR_W +: COLOR_W];
            plot_q      <= 1'b1;
            pix_cnt_q   <= pix_cnt_d;
            idle_cnt_q  <= '0;
          end else begin
            idle_cnt_q  <= idle_cnt_q + 1'b1;
          end
          if (end_normal || end_abort) begin
            grant_q        <= '0;
            burst_done_q   <= 1'b1;
            timeout_err_q  <= end_abort;
            done_id_q      <= 3'(owner_q);
            burst_pixels_q <= pix_cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            state_q        <= GAP;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant        = grant_q;
  assign bus.VGA_X        = vga_x_q;
  assign bus.VGA_Y        = vga_y_q;
  assign bus.VGA_COLOR    = vga_color_q;
  assign bus.plot         = plot_q;
  assign bus.burst_done   = burst_done_q;
  assign bus.done_id      = done_id_q;
  assign bus.burst_pixels = burst_pixels_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_draw_arbiter.sv
`default_nettype none
// ============================================================================
// tb_tile_draw_arbiter : directed, table-driven and random checks of the
//                        VGA port arbiter against a behavioural model.
// Rev 1.0
// ============================================================================
module tb_tile_draw_arbiter;
  import tile_draw_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TO = 2048;

  logic CLOCK_50 = 1'b0;
  logic reset;
  tile_draw_arbiter_if #(.NUM_REQ(N)) bus ();

  tile_draw_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  logic [3:0] pk_req;
  logic [1:0] pk_ptr;
  logic [1:0] pk_idx;
  logic       pk_found;

  draw_rr_pick #(.NUM_REQ(N), .IDX_W(2)) u_pick_tb (
    .req_i    (pk_req),
    .rr_ptr_i (pk_ptr),
    .idx_o    (pk_idx),
    .found_o  (pk_found)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int         m_owner, m_turn, m_cool, m_count, m_idle;
  bit         mv, ml;
  logic [3:0] e_grant;
  logic [9:0] e_x;
  logic [8:0] e_y, e_c;
  logic       e_plot, e_done, e_to;
  logic [2:0] e_id;
  logic [15:0] e_bp;

  always @(posedge CLOCK_50) begin
    if (!reset) begin
      m_owner = -1; m_turn = 0; m_cool = 0; m_count = 0; m_idle = 0;
      e_x = '0; e_y = '0; e_c = '0; e_plot = 0; e_done = 0; e_to = 0; e_id = '0; e_bp = '0;
    end else begin
      e_plot = 0; e_done = 0; e_to = 0;
      if (m_owner < 0) begin
        if (m_cool > 0) m_cool--;
        else begin
          for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && bus.req[(m_turn + k) % N]) begin
              m_owner = (m_turn + k) % N; m_count = 0; m_idle = 0;
            end
          end
        end
      end else begin
        mv = bus.req_valid[m_owner];
        ml = bus.req_last[m_owner];
        if (mv) begin
          e_x = bus.req_x[m_owner*10 +: 10];
          e_y = bus.req_y[m_owner*9 +: 9];
          e_c = bus.req_color[m_owner*9 +: 9];
          e_plot = 1;
          if (m_count < 65535) m_count++;
          m_idle = 0;
        end else begin
          m_idle++;
        end
        if ((mv && ml) || !bus.req[m_owner] || m_idle == TO) begin
          e_done = 1; e_to = !(mv && ml); e_id = 3'(m_owner); e_bp = 16'(m_count);
          m_turn = (m_owner + 1) % N; m_owner = -1; m_cool = 1;
        end
      end
    end
    e_grant = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
  end

  // ---------------- monitor ----------------
  bit  chk_en = 0;
  int  plot_cnt = 0, done_cnt = 0, gap_run = 0;
  logic [3:0] prev_grant = '0;
  int  glog[$];
  int  gaps[$];

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      chk("grant", 32'(bus.grant), 32'(e_grant));
      chk("plot", 32'(bus.plot), 32'(e_plot));
      chk("vga_x", 32'(bus.VGA_X), 32'(e_x));
      chk("vga_y", 32'(bus.VGA_Y), 32'(e_y));
      chk("vga_color", 32'(bus.VGA_COLOR), 32'(e_c));
      chk("burst_done", 32'(bus.burst_done), 32'(e_done));
      chk("timeout_err", 32'(bus.timeout_err), 32'(e_to));
      if (e_done) begin
        chk("done_id", 32'(bus.done_id), 32'(e_id));
        chk("burst_pixels", 32'(bus.burst_pixels), 32'(e_bp));
      end
      if (bus.plot) plot_cnt++;
      if (bus.burst_done) done_cnt++;
      if (bus.grant == 4'b0) gap_run++;
      else if (prev_grant == 4'b0) begin
        glog.push_back($clog2(bus.grant));
        gaps.push_back(gap_run);
        gap_run = 0;
      end
      prev_grant = bus.grant;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_pix(input int e, input logic v, input logic l,
                         input logic [9:0] x, input logic [8:0] y, input logic [8:0] c);
    bus.req_valid[e] = v;
    bus.req_last[e]  = l;
    bus.req_x[e*10 +: 10] = x;
    bus.req_y[e*9 +: 9]   = y;
    bus.req_color[e*9 +: 9] = c;
  endtask

  task automatic wait_grant(input logic [3:0] exp, input string name);
    int n;
    n = 0;
    while (bus.grant == 4'b0 && n < 50) begin
      step();
      n++;
    end
    chk(name, 32'(bus.grant), 32'(exp));
  endtask

  typedef struct packed {
    logic [3:0] req;
    logic [1:0] ptr;
    logic [1:0] idx;
    logic       found;
  } pick_vec_t;

  pick_vec_t pv[9];
  int sent[N];
  int p0, d0, n;

  initial begin
    reset = 1'b0;
    bus.req = '0; bus.req_valid = '0; bus.req_last = '0;
    bus.req_x = '0; bus.req_y = '0; bus.req_color = '0;

    pv[0] = '{4'b1111, 2'd0, 2'd0, 1'b1};
    pv[1] = '{4'b1111, 2'd2, 2'd2, 1'b1};
    pv[2] = '{4'b0001, 2'd3, 2'd0, 1'b1};
    pv[3] = '{4'b1000, 2'd1, 2'd3, 1'b1};
    pv[4] = '{4'b0110, 2'd3, 2'd1, 1'b1};
    pv[5] = '{4'b0101, 2'd1, 2'd2, 1'b1};
    pv[6] = '{4'b0011, 2'd2, 2'd0, 1'b1};
    pv[7] = '{4'b1010, 2'd0, 2'd1, 1'b1};
    pv[8] = '{4'b0000, 2'd1, 2'd0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      pk_req = pv[i].req;
      pk_ptr = pv[i].ptr;
      #1;
      chk("pick_found", 32'(pk_found), 32'(pv[i].found));
      if (pv[i].found) chk("pick_idx", 32'(pk_idx), 32'(pv[i].idx));
    end

    // Reset state
    step();
    chk_en = 1;
    step(); step();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_plot", 32'(bus.plot), 32'd0);
    chk("rst_vga_x", 32'(bus.VGA_X), 32'd0);
    chk("rst_vga_y", 32'(bus.VGA_Y), 32'd0);
    chk("rst_vga_color", 32'(bus.VGA_COLOR), 32'd0);
    chk("rst_done", 32'(bus.burst_done), 32'd0);
    chk("rst_done_id", 32'(bus.done_id), 32'd0);
    chk("rst_burst_pixels", 32'(bus.burst_pixels), 32'd0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    reset = 1'b1;

    // Single long burst from engine 1
    bus.req[1] = 1'b1;
    step();
    chk("single_grant", 32'(bus.grant), 32'h2);
    p0 = plot_cnt;
    for (int i = 0; i < 1200; i++) begin
      set_pix(1, 1'b1, i == 1199, 10'(40 + i % 40), 9'(30 + i / 40), WHITE);
      step();
    end
    set_pix(1, 1'b0, 1'b0, '0, '0, '0);
    bus.req[1] = 1'b0;
    chk("single_done", 32'(bus.burst_done), 32'd1);
    chk("single_id", 32'(bus.done_id), 32'd1);
    chk("single_pixels", 32'(bus.burst_pixels), 32'd1200);
    step();
    chk("single_plot_count", 32'(plot_cnt - p0), 32'd1200);

    // Full contention, 3-pixel bursts; idle engines drive junk valids
    reset = 1'b0;
    step();
    reset = 1'b1;
    glog.delete(); gaps.delete(); gap_run = 0;
    d0 = done_cnt;
    for (int e = 0; e < N; e++) sent[e] = 0;
    bus.req = '1;
    for (int cyc = 0; cyc < 200 && (done_cnt - d0) < 5; cyc++) begin
      for (int e = 0; e < N; e++) begin
        if (bus.grant[e]) begin
          set_pix(e, 1'b1, sent[e] == 2, 10'(e * 100 + sent[e]), 9'(e), GREEN);
          sent[e]++;
        end else begin
          sent[e] = 0;
          set_pix(e, 1'b1, 1'b1, 10'h3ff, 9'h1ff, 9'h1ff);
        end
      end
      step();
    end
    bus.req = '0; bus.req_valid = '0; bus.req_last = '0;
    chk("rr_burst_count", 32'(done_cnt - d0), 32'd5);
    for (int k = 0; k < 5; k++)
      chk("rr_order", 32'((k < glog.size()) ? glog[k] : 99), 32'(k % 4));
    for (int k = 1; k < 5; k++)
      chk("rr_gap_ge2", 32'((k < gaps.size()) && (gaps[k] >= 2)), 32'd1);

    // Timeout on engine 2
    bus.req[2] = 1'b1;
    wait_grant(4'b0100, "to_grant");
    for (int i = 0; i < 5; i++) begin
      set_pix(2, 1'b1, 1'b0, 10'(200 + i), 9'(i), GREEN);
      step();
    end
    set_pix(2, 1'b0, 1'b0, '0, '0, '0);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.burst_done && n < TO + 10);
    chk("to_idle_cycles", 32'(n), 32'(TO));
    chk("to_err", 32'(bus.timeout_err), 32'd1);
    chk("to_id", 32'(bus.done_id), 32'd2);
    chk("to_pixels", 32'(bus.burst_pixels), 32'd5);
    bus.req = '1;
    wait_grant(4'b1000, "to_next_rr");
    set_pix(3, 1'b1, 1'b1, 10'd5, 9'd5, WHITE);
    step();
    set_pix(3, 1'b0, 1'b0, '0, '0, '0);
    bus.req = '0;

    // Request drop on engine 0 while engine 2 waits
    bus.req = 4'b0101;
    wait_grant(4'b0001, "drop_grant");
    for (int i = 0; i < 10; i++) begin
      set_pix(0, 1'b1, 1'b0, 10'(300 + i), 9'(i), GREEN);
      step();
    end
    set_pix(0, 1'b0, 1'b0, '0, '0, '0);
    bus.req[0] = 1'b0;
    step();
    chk("drop_done", 32'(bus.burst_done), 32'd1);
    chk("drop_err", 32'(bus.timeout_err), 32'd1);
    chk("drop_id", 32'(bus.done_id), 32'd0);
    chk("drop_pixels", 32'(bus.burst_pixels), 32'd10);
    wait_grant(4'b0100, "drop_next");
    set_pix(2, 1'b1, 1'b1, 10'd7, 9'd7, WHITE);
    step();
    set_pix(2, 1'b0, 1'b0, '0, '0, '0);
    bus.req = '0;

    // Reset in the middle of a burst
    bus.req = 4'b1001;
    wait_grant(4'b1000, "mrst_grant");
    for (int i = 0; i < 16; i++) begin
      set_pix(3, 1'b1, 1'b0, 10'(500 + i), 9'(i), GREEN);
      step();
    end
    set_pix(3, 1'b1, 1'b0, 10'd516, 9'd16, GREEN);
    reset = 1'b0;
    step();
    chk("mrst_grant0", 32'(bus.grant), 32'd0);
    chk("mrst_plot0", 32'(bus.plot), 32'd0);
    chk("mrst_vga_x0", 32'(bus.VGA_X), 32'd0);
    chk("mrst_no_done", 32'(bus.burst_done), 32'd0);
    reset = 1'b1;
    set_pix(3, 1'b0, 1'b0, '0, '0, '0);
    wait_grant(4'b0001, "mrst_prio0");
    set_pix(0, 1'b1, 1'b1, 10'd9, 9'd9, WHITE);
    step();
    set_pix(0, 1'b0, 1'b0, '0, '0, '0);
    bus.req = '0;

    // Gapped valids ending in last
    bus.req[1] = 1'b1;
    wait_grant(4'b0010, "gap_grant");
    p0 = plot_cnt;
    for (int i = 0; i < 7; i++) begin
      set_pix(1, (i % 2) == 0, i == 6, 10'(600 + i), 9'(i), WHITE);
      step();
    end
    set_pix(1, 1'b0, 1'b0, '0, '0, '0);
    bus.req = '0;
    chk("gap_done", 32'(bus.burst_done), 32'd1);
    chk("gap_pixels", 32'(bus.burst_pixels), 32'd4);
    step();
    chk("gap_plot_count", 32'(plot_cnt - p0), 32'd4);

    // Random traffic against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int e = 0; e < N; e++) begin
        if (!bus.req[e]) bus.req[e] = ($urandom_range(7) == 0);
        else if ($urandom_range(63) == 0) bus.req[e] = 1'b0;
        set_pix(e, $urandom_range(1) == 1, $urandom_range(15) == 0,
                10'($urandom), 9'($urandom), 9'($urandom));
      end
      step();
    end
    bus.req = '0; bus.req_valid = '0; bus.req_last = '0;
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tile_draw_arbiter.md
Name: tile_draw_arbiter

Overview:
- Shares the single VGA pixel-write port between up to NUM_REQ tile-drawing engines, such as the spawn engine and the per-row shift engines.
- Grants are burst-locked: a winner keeps the port until it marks the last pixel of its tile.
- Arbitration is round-robin between bursts.
- Registers the pixel stream onto VGA_X/VGA_Y/VGA_COLOR with a plot strobe.
- Reports burst completion and stalled engines back to the top-level sequencer.

Parameters:
- NUM_REQ, 4, number of requesting draw engines (2..8).
- TIMEOUT, 2048, idle cycles allowed inside a granted burst before it is aborted.

Ports:
- CLOCK_50  input  1  system clock.
- reset  input  1  synchronous, active-low reset, sampled on posedge CLOCK_50.
- req  input  NUM_REQ  per-engine request; held high for the whole burst.
- req_valid  input  NUM_REQ  per-engine pixel valid.
- req_last  input  NUM_REQ  per-engine last pixel of burst; meaningful only with req_valid.
- req_x  input  NUM_REQ*10  packed X coordinates; engine i uses bits [10i+9:10i].
- req_y  input  NUM_REQ*9  packed Y coordinates.
- req_color  input  NUM_REQ*9  packed 9-bit colours.
- grant  output  NUM_REQ  one-hot grant, or all zero.
- VGA_X  output  10  registered pixel X.
- VGA_Y  output  9  registered pixel Y.
- VGA_COLOR  output  9  registered pixel colour.
- plot  output  1  write strobe for the VGA_* values.
- burst_done  output  1  one-cycle pulse at the end of a burst (normal or aborted).
- done_id  output  3  index of the engine whose burst ended.
- burst_pixels  output  16  number of pixels accepted in the ended burst.
- timeout_err  output  1  one-cycle pulse accompanying an aborted burst.

Behaviour:
- Reset values (reset==0 at a clock edge):
  - state=IDLE, grant=0, rr_ptr=0.
  - VGA_X=0, VGA_Y=0, VGA_COLOR=0, plot=0.
  - burst_done=0, done_id=0, burst_pixels=0, timeout_err=0.
  - Internal pixel and idle counters = 0.
- Reset mid-burst drops grant on the same edge; no burst_done is issued.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If any req bit is high, pick the first index g at or after rr_ptr, scanning upward modulo NUM_REQ.
  - Next edge: grant=onehot(g), pixel count=0, idle count=0, state=BUSY.
  - If no req bit is high, remain in IDLE.
- BUSY, pixel handling:
  - Only engine g's inputs are observed; all other valid/last bits are ignored.
  - On req_valid[g]: next edge loads VGA_X/Y/COLOR from slice g, sets plot=1, increments the pixel count (saturating at 16'hFFFF), and clears the idle count.
  - Latency from pixel in to pixel out is exactly 1 cycle.
  - plot=0 in any cycle that follows a cycle with no accepted pixel.
  - VGA_* hold their last values while plot=0.
- BUSY, normal end:
  - On req_valid[g] && req_last[g], the final pixel is still plotted.
  - On the same edge: grant=0, burst_done=1, done_id=g, burst_pixels=count+1, rr_ptr=(g+1) mod NUM_REQ, state=GAP.
- BUSY, abort:
  - Abort is triggered when req[g] falls without a last pixel, or when the idle count reaches TIMEOUT-1 with no valid.
  - On abort: grant=0, burst_done=1, timeout_err=1, done_id=g, burst_pixels=count, rr_ptr advances as in a normal end, state=GAP.
  - If valid and req-fall occur in the same cycle, the pixel is accepted, then the burst is aborted.
- GAP: exactly one cycle with grant=0; then IDLE. Consecutive bursts therefore have at least 2 cycles with grant=0 between them.
- Fairness:
  - If every engine requests continuously, grants rotate 0,1,2,...,NUM_REQ-1,0.
  - A single requester is re-granted after the turnaround.
- A req bit that rises while another engine owns the port is simply served later; no request is lost while it stays high.
- Width rules:
  - Slice indexing is fixed per the Ports section.
  - done_id is zero-extended to 3 bits.
  - The idle counter is wide enough for TIMEOUT (clog2).
- burst_done and timeout_err are never high for more than one consecutive cycle.

Decomposition:
- Shared package holds:
  - X_W=10, Y_W=9, COLOR_W=9.
  - State encodings IDLE=2'd0, BUSY=2'd1, GAP=2'd2.
  - Colour constants WHITE=9'h1ff, GREEN=9'h0a0.
- One natural sub-module, draw_rr_pick: combinational rotate-priority encoder that takes req and rr_ptr and returns an index plus a found flag. Arbitration is tested in isolation through it.

Test Plan:
- Single burst: req[1] high, 1200 valid pixels with last on the 1200th, X 40..79, Y 30..59, colour 9'h1ff.
  -> grant=4'b0010 one cycle after req.
  -> Exactly 1200 plot cycles, each matching its input one cycle later.
  -> burst_done with done_id=1 and burst_pixels=1200.
- Full contention: all four req high, each engine doing 3-pixel bursts.
  -> Grant order 0,1,2,3,0.
  -> At least 2 grant-free cycles between bursts.
  -> No plot from a non-granted engine, even when it drives valid.
- Timeout: grant engine 2, send 5 pixels, then hold valid low with req high.
  -> burst_done, timeout_err=1, done_id=2, burst_pixels=5 after TIMEOUT idle cycles.
  -> rr_ptr=3, so engine 3 wins next.
- Request drop: engine 0 drops req after 10 pixels with no last.
  -> Abort on that edge, timeout_err=1, burst_pixels=10.
  -> Next grant goes to the next requester.
- Mid-burst reset: assert reset=0 for one cycle during pixel 17 of a burst.
  -> Next cycle: grant=0, plot=0, VGA_X=0, no burst_done.
  -> After release, engine 0 has priority.
- Gapped valids: last pixel arrives while valid toggles 1,0,1,0.
  -> plot follows the toggling delayed by 1 cycle; burst_pixels equals the number of valid cycles.
